// File: rtl/branch_predictor_pkg.sv
// Shared predictor types: 2-bit counter encoding
// and its saturating step function.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_t;

  function automatic cnt_t cnt_step(
    input cnt_t c,
    input logic up
  );
    if (up) return (c == ST) ? ST : cnt_t'(c + 2'd1);
    return (c == SNT) ? SNT : cnt_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating up/down counter, one per BTB
// entry; load forces WT on allocation.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic up_i,
  input  logic load_i,
  output cnt_t cnt_o
);

  cnt_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      load_i:  cnt_d = WT;
      en_i:    cnt_d = cnt_step(cnt_q, up_i);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= WNT;
    else      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// Flop-based BTB with 2-bit counters, F->D->E
// prediction record and E-stage resolution.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_f,
  input  logic            stall_d,
  input  logic            flush_d,
  input  logic            flush_e,
  input  logic            ex_branch,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc
);

  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [N-1:0]      vld_q;
  logic [TAG_W-1:0]  tag_q [N];
  logic [XLEN-1:0]   tgt_q [N];
  cnt_t              cnt   [N];

  logic              d_vld_q, e_vld_q;
  logic [XLEN-1:0]   d_pc_q, e_pc_q;
  logic              d_pt_q, e_pt_q;
  logic [XLEN-1:0]   d_tgt_q, e_tgt_q;

  logic [IDX_W-1:0]  idx_f, idx_e;
  logic [TAG_W-1:0]  tag_f, tag_e;
  logic              hit_f, hit_e;
  logic [XLEN-1:0]   pc_e4;
  logic              upd_br, cnt_en, alloc, inval;

  assign idx_f = pc_f[IDX_W+1:2];
  assign tag_f = pc_f[XLEN-1:IDX_W+2];
  assign hit_f = vld_q[idx_f] &
                 (tag_q[idx_f] == tag_f);

  assign pred_taken  = hit_f &
                       (cnt[idx_f] inside {WT, ST});
  assign pred_target = pred_taken ? tgt_q[idx_f]
                                  : pc_f + XLEN'(4);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_vld_q <= 1'b0;
      e_vld_q <= 1'b0;
      d_pc_q  <= '0;
      e_pc_q  <= '0;
      d_pt_q  <= 1'b0;
      e_pt_q  <= 1'b0;
      d_tgt_q <= '0;
      e_tgt_q <= '0;
    end else begin
      if (flush_d)       d_vld_q <= 1'b0;
      else if (!stall_d) d_vld_q <= 1'b1;
      if (!stall_d) begin
        d_pc_q  <= pc_f;
        d_pt_q  <= pred_taken;
        d_tgt_q <= pred_target;
      end
      e_vld_q <= d_vld_q & ~flush_e;
      e_pc_q  <= d_pc_q;
      e_pt_q  <= d_pt_q;
      e_tgt_q <= d_tgt_q;
    end
  end

  // Second read port re-checks the entry at E time
  assign idx_e = e_pc_q[IDX_W+1:2];
  assign tag_e = e_pc_q[XLEN-1:IDX_W+2];
  assign hit_e = vld_q[idx_e] &
                 (tag_q[idx_e] == tag_e);
  assign pc_e4 = e_pc_q + XLEN'(4);

  always_comb begin
    mispredict  = 1'b0;
    redirect_pc = pc_e4;
    if (ex_branch) begin
      if (ex_taken) redirect_pc = ex_target;
      mispredict = e_vld_q &
        ((ex_taken != e_pt_q) |
         (ex_taken & e_pt_q &
          (ex_target != e_tgt_q)));
    end else begin
      mispredict = e_vld_q & e_pt_q;
    end
  end

  assign upd_br = e_vld_q & ex_branch;
  assign cnt_en = upd_br & hit_e;
  assign alloc  = upd_br & ~hit_e & ex_taken;
  assign inval  = e_vld_q & ~ex_branch &
                  e_pt_q & hit_e;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      for (int i = 0; i < N; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else begin
      if (alloc) begin
        vld_q[idx_e] <= 1'b1;
        tag_q[idx_e] <= tag_e;
      end
      if (inval) vld_q[idx_e] <= 1'b0;
      if (alloc | (cnt_en & ex_taken))
        tgt_q[idx_e] <= ex_target;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_cnt
    sat_counter2 u_cnt (
      .clk    (clk),
      .rst    (rst),
      .en_i   (cnt_en & (idx_e == IDX_W'(i))),
      .up_i   (ex_taken),
      .load_i (alloc & (idx_e == IDX_W'(i))),
      .cnt_o  (cnt[i])
    );
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with
// hand-computed expectations.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_f;
  logic        stall_d, flush_d, flush_e;
  logic        ex_branch, ex_taken;
  logic [31:0] ex_target;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] FILL = 32'h404;

  branch_predictor #(.IDX_W(4), .XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_f        (pc_f),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .flush_e     (flush_e),
    .ex_branch   (ex_branch),
    .ex_taken    (ex_taken),
    .ex_target   (ex_target),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .mispredict  (mispredict),
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [31:0] pc,
                      input logic exp_pt,
                      input logic [31:0] exp_tgt);
    pc_f = pc;
    #1;
    chk("look_pt", {31'd0, pred_taken},
        {31'd0, exp_pt});
    chk("look_tgt", pred_target,
        exp_pt ? exp_tgt : pc + 32'd4);
  endtask

  // Fetch pc, carry it to E, resolve it there
  task automatic run_br(input logic [31:0] pc,
                        input logic br,
                        input logic tk,
                        input logic [31:0] tgt,
                        input logic exp_pt,
                        input logic [31:0] exp_tgt);
    logic exp_mp;
    logic [31:0] exp_rd;
    look(pc, exp_pt, exp_tgt);
    tick;
    pc_f = FILL;
    tick;
    ex_branch = br;
    ex_taken  = tk;
    ex_target = tgt;
    exp_mp = br ? ((tk != exp_pt) |
                   (tk & exp_pt & (tgt != exp_tgt)))
                : exp_pt;
    exp_rd = (br & tk) ? tgt : pc + 32'd4;
    #1;
    chk("mp", {31'd0, mispredict},
        {31'd0, exp_mp});
    if (exp_mp) chk("redir", redirect_pc, exp_rd);
    tick;
    ex_branch = 1'b0;
    ex_taken  = 1'b0;
    ex_target = '0;
  endtask

  initial begin
    rst = 1'b0;
    pc_f = 32'h100;
    stall_d = 0; flush_d = 0; flush_e = 0;
    ex_branch = 0; ex_taken = 0; ex_target = 0;
    #12;
    chk("rst_pt", {31'd0, pred_taken}, 32'd0);
    chk("rst_tgt", pred_target, 32'h104);
    chk("rst_mp", {31'd0, mispredict}, 32'd0);
    rst = 1'b1;
    tick;

    look(32'h100, 0, 0);
    run_br(32'h100, 1, 1, 32'h200, 0, 0);
    run_br(32'h100, 1, 1, 32'h200, 1, 32'h200);
    run_br(32'h100, 1, 1, 32'h200, 1, 32'h200);
    run_br(32'h100, 1, 1, 32'h200, 1, 32'h200);
    run_br(32'h100, 1, 1, 32'h200, 1, 32'h200);
    run_br(32'h100, 1, 0, 0, 1, 32'h200);
    run_br(32'h100, 1, 0, 0, 1, 32'h200);
    run_br(32'h100, 1, 0, 0, 0, 0);
    run_br(32'h100, 1, 0, 0, 0, 0);
    run_br(32'h100, 1, 1, 32'h200, 0, 0);
    run_br(32'h100, 1, 1, 32'h300, 0, 0);
    run_br(32'h100, 1, 1, 32'h340, 1, 32'h300);
    look(32'h100, 1, 32'h340);

    look(32'h140, 0, 0);
    run_br(32'h100, 0, 0, 0, 1, 32'h340);
    look(32'h100, 0, 0);

    pc_f = 32'h508;
    tick;
    stall_d = 1;
    pc_f = 32'h50C;
    tick;
    tick;
    ex_branch = 1; ex_taken = 0;
    #1;
    chk("stl_rd", redirect_pc, 32'h50C);
    chk("stl_mp", {31'd0, mispredict}, 32'd0);
    ex_branch = 0;
    flush_e = 1;
    tick;
    flush_e = 0;
    ex_branch = 1; ex_taken = 1; ex_target = 32'h900;
    #1;
    chk("fle_mp", {31'd0, mispredict}, 32'd0);
    ex_branch = 0; ex_taken = 0;
    stall_d = 0;
    tick;
    ex_branch = 1;
    #1;
    chk("hold_rd", redirect_pc, 32'h50C);
    ex_taken = 1;
    #1;
    chk("hold_mp", {31'd0, mispredict}, 32'd1);
    chk("hold_trd", redirect_pc, 32'h900);
    ex_branch = 0; ex_taken = 0;
    stall_d = 1; flush_d = 1;
    tick;
    flush_d = 0;
    tick;
    ex_branch = 1; ex_taken = 1;
    #1;
    chk("fld_mp", {31'd0, mispredict}, 32'd0);
    ex_branch = 0; ex_taken = 0; ex_target = 0;
    stall_d = 0;
    tick;
    tick;

    run_br(32'h10C, 1, 1, 32'h400, 0, 0);
    look(32'h10C, 1, 32'h400);
    pc_f = 32'h600;
    tick;
    pc_f = FILL;
    tick;
    ex_branch = 1; ex_taken = 1; ex_target = 32'h700;
    #1;
    chk("rmid_mp", {31'd0, mispredict}, 32'd1);
    #2;
    rst = 1'b0;
    tick;
    chk("rmid_pt", {31'd0, pred_taken}, 32'd0);
    rst = 1'b1;
    ex_branch = 0; ex_taken = 0; ex_target = 0;
    chk("post_mp", {31'd0, mispredict}, 32'd0);
    look(32'h600, 0, 0);
    look(32'h10C, 0, 0);
    look(32'h100, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=done");
    $fatal(1);
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter IDX_W, default 4, BTB index width; the BTB has 2^IDX_W entries.
REQ-002 Parameter XLEN, default 32, PC and target width.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 pc_f  in  XLEN  fetch-stage PC; bits [1:0] are always 0.
REQ-006 stall_d  in  1  hazard-unit stall; holds the F->D prediction slot.
REQ-007 flush_d, flush_e  in  1 each  hazard-unit flushes of the D and E prediction slots.
REQ-008 ex_branch  in  1  the instruction in E is a B/BL.
REQ-009 ex_taken  in  1  resolved direction (Branch & CondEx from the conditional logic).
REQ-010 ex_target  in  XLEN  resolved branch target from the E-stage ALU.
REQ-011 pred_taken  out  1  fetch prediction for pc_f.
REQ-012 pred_target  out  XLEN  predicted next PC when pred_taken=1, else pc_f+4.
REQ-013 mispredict  out  1  E-stage misprediction; the hazard unit flushes D and E.
REQ-014 redirect_pc  out  XLEN  corrected fetch PC, valid when mispredict=1.

Function
REQ-015 Each BTB entry SHALL hold valid, tag = PC[XLEN-1:IDX_W+2], target, and a 2-bit counter: SNT=00, WNT=01, WT=10, ST=11.
REQ-016 Lookup SHALL be combinational from pc_f: hit = valid & tag match; pred_taken = hit & counter[1].
REQ-017 The prediction record {valid, pc, pred_taken, pred_target} SHALL move F->D on each edge unless stall_d=1; it SHALL move D->E on each edge.
REQ-018 flush_d SHALL clear the D-slot valid bit, and flush_e SHALL clear the E-slot valid bit, on the next edge; a flush SHALL override a stall.
REQ-019 mispredict SHALL be combinational from the E slot and the ex_* inputs, and SHALL be 0 unless the E slot is valid.
REQ-020 When ex_branch=1, mispredict SHALL be 1 if ex_taken != pred_taken, or if both are 1 and ex_target != pred_target.
REQ-021 When ex_branch=1, redirect_pc SHALL be ex_target if ex_taken=1, else pc_e+4.
REQ-022 When ex_branch=0 and pred_taken=1 (alias), mispredict SHALL be 1, redirect_pc SHALL be pc_e+4, and the entry SHALL be invalidated on the next edge.
REQ-023 Update on a valid E slot with ex_branch=1 and a hit: the counter SHALL saturating-increment if taken and saturating-decrement if not; the target SHALL be overwritten when taken.
REQ-024 Update on a miss: if taken, the entry SHALL be allocated with valid=1, tag, target=ex_target and counter=WT; if not taken, there SHALL be no change.
REQ-025 Saturation: ST+taken SHALL stay ST, and SNT+not-taken SHALL stay SNT.
REQ-026 When an update and a lookup hit the same index in the same cycle, the lookup SHALL see the pre-update contents.
REQ-027 Latency: resolution to table update SHALL be 1 edge, and an updated entry SHALL be visible to a lookup in the following cycle.

Reset
REQ-028 While rst=0, all valid bits SHALL be cleared, all counters set to WNT, and both slots invalidated; targets and tags are don't-care.
REQ-029 Out of reset, pred_taken=0, pred_target=pc_f+4 and mispredict=0.
REQ-030 An asynchronous reset asserted mid-operation SHALL discard any in-flight update.

Structure
REQ-031 Counter encodings and the ST/WT/WNT/SNT constants SHALL live in the shared processor package.
REQ-032 A single sub-module, sat_counter2 (2-bit saturating up/down counter), SHALL be instantiated per entry.
REQ-033 The BTB SHALL be flop-based with no RAM macro.

Verification
REQ-034 Reset, then pc_f=0x100 -> pred_taken=0, pred_target=0x104.
REQ-035 Branch at 0x100 resolves taken to 0x200; next lookup of 0x100 -> pred_taken=1, pred_target=0x200, counter=WT.
REQ-036 Four consecutive taken resolutions then one not-taken -> counter ST then WT, still predicted taken; a not-taken resolution with pred_taken=1 -> mispredict=1, redirect_pc=0x104.
REQ-037 Alias: 0x140 maps to the 0x100 entry with a different tag -> miss; a non-branch in E with pred_taken=1 -> mispredict=1, redirect=pc_e+4, entry invalidated.
REQ-038 stall_d=1 for 2 cycles, then flush_e=1 -> the D record is held, E is invalid, and mispredict stays 0.
REQ-039 rst pulsed low during a taken-update cycle -> no allocation, and all lookups miss afterward.
